param_seq_detector: RTL and testbench
=====================================

Name: param_seq_detector

Overview:
- Runtime-programmable serial bit-pattern detector. Generalises the fixed "1101" Moore detector to any pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection, an input-valid qualifier and a saturating match counter.
- Sits on a serial input stream. It feeds a registered one-cycle match pulse and the match count to downstream control or status logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must satisfy 2**LEN_W > MAX_LEN.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe; captures cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 is the last; bits above cfg_len-1 are ignored.
- cfg_len  input  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  qualifies x; a bit is accepted only when in_valid=1.
- x  input  1  serial data bit.
- count_clr  input  1  synchronous clear of match_count.
- z  output  1  registered match pulse, high for one cycle per detection.
- match_count  output  CNT_W  saturating number of detections.
- armed  output  1  1 when in RUN state.
- cfg_err  output  1  sticky flag for an illegal cfg_len, cleared by the next legal cfg_load.

Behaviour:
- Reset (synchronous, reset=1 at edge) values:
  - state=IDLE, z=0, match_count=0, armed=0, cfg_err=0.
  - Pattern, length, overlap and history registers = 0; fill=0.
  - Reset overrides every other input in the same cycle.
- FSM with two states, IDLE and RUN; armed = (state==RUN).
  - IDLE: in_valid/x ignored, z=0. A cfg_load with legal length moves to RUN; an illegal length stays in IDLE and sets cfg_err=1.
  - RUN: a cfg_load with legal length stays in RUN with the new config. An illegal length returns to IDLE and sets cfg_err=1.
- Every cfg_load, legal or not, clears history and fill. A legal load clears cfg_err. match_count is not affected.
- cfg_load and in_valid in the same cycle: the load wins and the bit is discarded.
- History and fill:
  - hist is a MAX_LEN-bit shift register with the newest bit in hist[0]. An accepted bit updates hist <= {hist[MAX_LEN-2:0], x}.
  - fill counts accepted bits since the last clear and saturates at MAX_LEN.
- Match condition, evaluated on an accepted bit in RUN using the post-shift values: fill' >= cfg_len and hist'[cfg_len-1:0] == pattern[cfg_len-1:0].
- Latency: z=1 in the cycle immediately after the edge that accepts the completing bit (one-cycle registered). z=0 in all other cycles, including cycles where in_valid=0.
- Overlap handling:
  - Overlap mode: history is kept after a match, so a suffix can start the next match.
  - Non-overlap mode: a match sets fill=0 on the same edge, so the next match needs cfg_len fresh bits.
- match_count:
  - Increments by 1 on the same edge that sets z. It holds at 2**CNT_W-1 once saturated.
  - count_clr sets it to 0. If count_clr and a match occur together, the clear wins (result 0) but z still pulses.
- in_valid=0: hist, fill and z (which goes to 0) hold no pending state; nothing else changes. Gaps of any length are transparent to detection.
- Reset mid-stream discards all history and configuration. The block returns to IDLE and a new cfg_load is needed.

Test Plan:
- Overlap match: load pattern=8'b0000_1101, len=4, overlap=1; stream 1,1,0,1,1,0,1 with in_valid=1 -> z pulses after bits 4 and 7; match_count=2.
- Non-overlap match: same stream with overlap=0 -> z pulses only after bit 4; match_count=1.
- Input gaps: stream 1,1,(in_valid=0 for 3 cycles),0,1 -> one z pulse, one cycle after the final bit; z=0 during the gap.
- Illegal config: cfg_len=0 (and separately cfg_len=9 with MAX_LEN=8) -> cfg_err=1, armed=0, no z on any stream. A subsequent legal load -> cfg_err=0, armed=1.
- Saturation and clear: CNT_W=2, pattern=1'b1, len=1, five 1s -> five z pulses, match_count=3. count_clr together with a sixth 1 -> z=1, match_count=0.
- Reset mid-stream: after 1,1,0, assert reset one cycle, then send 1 -> z stays 0, armed=0, match_count=0. Reload the config and send 1,1,0,1 -> one z pulse.

Source files
------------

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits)
// with overlap control, valid qualifier and saturating match count.
module param_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               count_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               len_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LEN_W-1:0]   fill_nx;
  logic [MAX_LEN-1:0] len_mask;
  logic               pat_hit;
  logic               hit;

  assign len_ok  = (cfg_len != '0) && (cfg_len <= FILL_MAX);
  assign accept  = (state_q == RUN) && in_valid && !cfg_load;
  assign hist_sh = {hist_q[MAX_LEN-2:0], x};
  assign fill_nx = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

  // Select only the low len_q bits of history for comparison
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign pat_hit = ((hist_sh ^ pat_q) & len_mask) == '0;
  assign hit     = accept && (fill_nx >= len_q) && pat_hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: legal loads arm, illegal loads disarm
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_load && len_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_load && !len_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: config, history, fill, pulse, counter
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    err_d  = err_q;
    z_d    = hit;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      err_d  = !len_ok;
      if (len_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
      end
    end else if (accept) begin
      hist_d = hist_sh;
      // Non-overlap restarts the fill so the next match needs fresh bits
      fill_d = (hit && !ovl_q) ? '0 : fill_nx;
    end

    if (count_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Outputs
  always_comb begin
    armed       = (state_q == RUN);
    z           = z_q;
    match_count = cnt_q;
    cfg_err     = err_q;
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector (MAX_LEN=8, CNT_W=2)
// using a queue-of-bits reference model.
module tb_param_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       x;
  logic       count_clr;
  logic       z;
  logic [1:0] match_count;
  logic       armed;
  logic       cfg_err;

  param_seq_detector #(
    .MAX_LEN(8),
    .LEN_W  (4),
    .CNT_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .in_valid   (in_valid),
    .x          (x),
    .count_clr  (count_clr),
    .z          (z),
    .match_count(match_count),
    .armed      (armed),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       z;
    logic [1:0] cnt;
    logic       armed;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  logic       m_run;
  logic       m_err;
  logic       m_ovl;
  logic [7:0] m_pat;
  int         m_len;
  logic [1:0] m_cnt;
  int         seq[$];

  // Reference model: accepted bits kept as a list, newest at the back
  task automatic model(input logic ld, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl,
                       input logic iv, input logic xb,
                       input logic clr, input logic rst);
    exp_t e;
    logic ez;
    bit   ok;
    ez = 1'b0;
    if (rst) begin
      m_run = 0; m_err = 0; m_ovl = 0; m_pat = '0;
      m_len = 0; m_cnt = '0; seq.delete();
    end else begin
      if (ld) begin
        seq.delete();
        if (len >= 1 && len <= 8) begin
          m_run = 1; m_err = 0;
          m_pat = pat; m_len = int'(len); m_ovl = ovl;
        end else begin
          m_run = 0; m_err = 1;
        end
      end else if (m_run && iv) begin
        seq.push_back(int'(xb));
        if (seq.size() > 8) void'(seq.pop_front());
        if (seq.size() >= m_len) begin
          ok = 1;
          for (int k = 0; k < m_len; k++)
            if (seq[seq.size()-1-k] != int'(m_pat[k])) ok = 0;
          if (ok) begin
            ez = 1'b1;
            if (!m_ovl) seq.delete();
          end
        end
      end
      if (clr) m_cnt = '0;
      else if (ez && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end
    e.z = ez; e.cnt = m_cnt; e.armed = m_run; e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (z === e.z) else begin
      miscompares++;
      $error("FAIL z observed=%b expected=%b", z, e.z);
    end
    vectors++;
    assert (match_count === e.cnt) else begin
      miscompares++;
      $error("FAIL match_count observed=%0d expected=%0d",
             match_count, e.cnt);
    end
    vectors++;
    assert (armed === e.armed) else begin
      miscompares++;
      $error("FAIL armed observed=%b expected=%b", armed, e.armed);
    end
    vectors++;
    assert (cfg_err === e.err) else begin
      miscompares++;
      $error("FAIL cfg_err observed=%b expected=%b", cfg_err, e.err);
    end
  endtask

  task automatic step(input logic ld, input logic [7:0] pat,
                      input logic [3:0] len, input logic ovl,
                      input logic iv, input logic xb,
                      input logic clr, input logic rst);
    reset = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; in_valid = iv; x = xb; count_clr = clr;
    model(ld, pat, len, ovl, iv, xb, clr, rst);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic bit_in(input logic xb);
    step(0, 8'h00, 4'd0, 0, 1, xb, 0, 0);
  endtask

  task automatic gap();
    step(0, 8'h00, 4'd0, 0, 0, 1, 0, 0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl);
    step(1, pat, len, ovl, 0, 0, 0, 0);
  endtask

  task automatic clr_cnt();
    step(0, 8'h00, 4'd0, 0, 0, 0, 1, 0);
  endtask

  task automatic expect_val(input string tag, input int obs,
                            input int exp_v);
    vectors++;
    assert (obs == exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic stream_1101101();
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    bit_in(1); bit_in(0); bit_in(1);
  endtask

  initial begin
    reset = 1; cfg_load = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; in_valid = 0; x = 0; count_clr = 0;
    #2;
    step(0, 8'h00, 4'd0, 0, 0, 0, 0, 1);
    step(0, 8'h00, 4'd0, 0, 1, 1, 0, 1);
    expect_val("reset_armed", int'(armed), 0);

    load(8'b0000_1101, 4'd4, 1);
    stream_1101101();
    expect_val("ovl_count", int'(match_count), 2);
    clr_cnt();

    load(8'b0000_1101, 4'd4, 0);
    stream_1101101();
    expect_val("novl_count", int'(match_count), 1);
    clr_cnt();

    load(8'b0000_1101, 4'd4, 1);
    bit_in(1); bit_in(1);
    gap(); gap(); gap();
    bit_in(0);
    bit_in(1);
    expect_val("gap_z", int'(z), 1);
    clr_cnt();

    step(1, 8'b0000_1101, 4'd4, 1, 1, 1, 0, 0);
    bit_in(1); bit_in(0); bit_in(1);
    expect_val("load_wins_z", int'(z), 0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    clr_cnt();

    load(8'b0000_1101, 4'd0, 1);
    expect_val("len0_err", int'(cfg_err), 1);
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    load(8'b0000_1101, 4'd9, 1);
    expect_val("len9_armed", int'(armed), 0);
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    load(8'b0000_1101, 4'd4, 1);
    expect_val("legal_err", int'(cfg_err), 0);
    expect_val("legal_armed", int'(armed), 1);

    load(8'b0000_0001, 4'd1, 1);
    for (int i = 0; i < 5; i++) bit_in(1);
    expect_val("sat_count", int'(match_count), 3);
    step(0, 8'h00, 4'd0, 0, 1, 1, 1, 0);
    expect_val("clr_hit_z", int'(z), 1);
    expect_val("clr_hit_cnt", int'(match_count), 0);

    load(8'b0000_1101, 4'd4, 1);
    bit_in(1); bit_in(1); bit_in(0);
    step(0, 8'h00, 4'd0, 0, 0, 0, 0, 1);
    bit_in(1);
    expect_val("rst_mid_z", int'(z), 0);
    load(8'b0000_1101, 4'd4, 1);
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    expect_val("reload_cnt", int'(match_count), 1);
    bit_in(0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
